// File: rtl/mvb_frame_sched.sv
// Purpose : transmit scheduler feeding the MVB encoder; arbitrates master/slave frame requests and fetches words.
// Latency : master ack->send_frame 2 cycles, slave ack->send_frame 3 cycles; refetched word valid 2 cycles after enc_next.
// Backpr. : requests are held by the requester until acked; acks are given only in IDLE, so later requests wait.
module mvb_frame_sched #(
    parameter int GAP_CYCLES = 48,
    parameter int TMO_CYCLES = 8192
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        m_req,
    input  logic [15:0] m_word,
    output logic        m_ack,
    input  logic        s_req,
    input  logic [2:0]  s_len,
    output logic        s_ack,
    output logic        s_rd,
    output logic [3:0]  s_addr,
    input  logic [15:0] s_data,
    input  logic        enc_busy,
    input  logic        enc_next,
    output logic        M_frame,
    output logic        S_frame,
    output logic [6:0]  frame_length,
    output logic [15:0] data_in,
    output logic        send_frame,
    output logic        sched_idle,
    output logic        err_len,
    output logic        err_tmo
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(TMO_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        XMIT  = 3'd3,
        DRAIN = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           last_m_q;       // 1: last granted frame was master
    logic           m_frame_q;
    logic           s_frame_q;
    logic [6:0]     len_q;
    logic [4:0]     rem_q;          // words not yet taken by the encoder
    logic [15:0]    data_q;
    logic           s_rd_q;
    logic [3:0]     s_addr_q;
    logic           ld_q;           // s_data carries the word fetched last cycle
    logic           err_tmo_q;
    logic [GW-1:0]  gap_q;
    logic [TW-1:0]  tmo_q;

    logic           grant_m, grant_s;
    logic           tmo_fire;
    logic           progress;
    logic           tmo_done;
    logic           slave_ok;

    assign slave_ok = (s_len <= 3'd4);
    assign progress = ((state_q == XMIT) && enc_next) || ((state_q == DRAIN) && !enc_busy);
    assign tmo_done = (tmo_q == TW'(TMO_CYCLES - 1));

    // State register.
    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state, arbitration and the combinational ack/error pulses.
    always_comb begin
        state_d  = state_q;
        m_ack    = 1'b0;
        s_ack    = 1'b0;
        err_len  = 1'b0;
        grant_m  = 1'b0;
        grant_s  = 1'b0;
        tmo_fire = 1'b0;
        case (state_q)
            IDLE: begin
                // An illegal slave request is rejected first; a waiting master follows next cycle.
                if (s_req && !slave_ok) begin
                    s_ack   = 1'b1;
                    err_len = 1'b1;
                end else if (m_req && (!s_req || !last_m_q)) begin
                    m_ack   = 1'b1;
                    grant_m = 1'b1;
                    state_d = FETCH;
                end else if (s_req) begin
                    s_ack   = 1'b1;
                    grant_s = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (m_frame_q || ld_q) state_d = START;
            end
            START: state_d = XMIT;
            XMIT: begin
                if (enc_next) begin
                    if (rem_q <= 5'd1) state_d = DRAIN;
                end else if (tmo_done) begin
                    tmo_fire = 1'b1;
                    state_d  = GAP;
                end
            end
            DRAIN: begin
                if (!enc_busy) begin
                    state_d = GAP;
                end else if (tmo_done) begin
                    tmo_fire = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Frame context latched at grant, word fetch sequencing and the data word register.
    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            last_m_q  <= 1'b0;
            m_frame_q <= 1'b0;
            s_frame_q <= 1'b0;
            len_q     <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            s_rd_q    <= 1'b0;
            s_addr_q  <= '0;
            ld_q      <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            s_rd_q    <= 1'b0;
            ld_q      <= s_rd_q;
            err_tmo_q <= tmo_fire;
            if (ld_q) data_q <= s_data;
            if (grant_m) begin
                last_m_q  <= 1'b1;
                m_frame_q <= 1'b1;
                s_frame_q <= 1'b0;
                len_q     <= 7'd1;
                rem_q     <= 5'd1;
                data_q    <= m_word;
            end
            if (grant_s) begin
                last_m_q  <= 1'b0;
                m_frame_q <= 1'b0;
                s_frame_q <= 1'b1;
                len_q     <= 7'd1 << s_len;
                rem_q     <= 5'd1 << s_len;
                s_rd_q    <= 1'b1;
                s_addr_q  <= '0;
            end
            // Each accepted word frees the data register; fetch the next one if any remain.
            if ((state_q == XMIT) && enc_next && (rem_q != 5'd0)) begin
                rem_q <= rem_q - 5'd1;
                if (rem_q > 5'd1) begin
                    s_rd_q   <= 1'b1;
                    s_addr_q <= s_addr_q + 4'd1;
                end
            end
            if ((state_q == GAP) && (state_d == IDLE)) begin
                m_frame_q <= 1'b0;
                s_frame_q <= 1'b0;
                len_q     <= '0;
            end
        end
    end

    // Gap counter runs only in GAP; timeout counter reloads on progress or outside XMIT/DRAIN.
    always_ff @(posedge clk_24M or negedge rst) begin
        if (!rst) begin
            gap_q <= '0;
            tmo_q <= '0;
        end else begin
            if ((state_q == GAP) && (gap_q < GW'(GAP_CYCLES))) gap_q <= gap_q + 1'b1;
            else if (state_q != GAP)                             gap_q <= '0;
            if (((state_q == XMIT) || (state_q == DRAIN)) && !progress) begin
                if (tmo_q < TW'(TMO_CYCLES)) tmo_q <= tmo_q + 1'b1;
            end else begin
                tmo_q <= '0;
            end
        end
    end

    // The fetched word is forwarded straight from s_data during its capture cycle.
    assign data_in      = ld_q ? s_data : data_q;
    assign M_frame      = m_frame_q;
    assign S_frame      = s_frame_q;
    assign frame_length = len_q;
    assign s_rd         = s_rd_q;
    assign s_addr       = s_addr_q;
    assign err_tmo      = err_tmo_q;
    assign send_frame   = (state_q == START);
    assign sched_idle   = (state_q == IDLE);

endmodule

// File: doc/mvb_frame_sched.md
# mvb_frame_sched

Transmit-side scheduler for the MVB encoder: arbitrates between a master-frame requester and a slave-frame requester, fetches frame words, drives the encoder's frame controls (`M_frame`, `S_frame`, `frame_length`, `data_in`, `send_frame`) and enforces an inter-frame idle gap. It sits between the link-layer request logic and `Encode`, in the `clk_24M` domain, and is the sole driver of the encoder's control inputs.

## Interface
- `GAP_CYCLES`, 48: idle `clk_24M` cycles enforced after the encoder drops `enc_busy` (2 µs).
- `TMO_CYCLES`, 8192: maximum cycles without encoder progress before the frame is aborted.
- `clk_24M`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `m_req`  in  1  master frame request; level, held until `m_ack`.
- `m_word`  in  16  master frame content; stable while `m_req`.
- `m_ack`  out  1  one-cycle pulse: master request accepted.
- `s_req`  in  1  slave frame request; level, held until `s_ack`.
- `s_len`  in  3  slave length code: 0..4 → 1,2,4,8,16 words; 5..7 illegal.
- `s_ack`  out  1  one-cycle pulse: slave request accepted or rejected.
- `s_rd`  out  1  one-cycle word-fetch strobe.
- `s_addr`  out  4  word index being fetched.
- `s_data`  in  16  fetched word, valid the cycle after `s_rd`.
- `enc_busy`  in  1  encoder transmitting.
- `enc_next`  in  1  one-cycle pulse: encoder latched current `data_in`.
- `M_frame`, `S_frame`  out  1 each  frame type to encoder.
- `frame_length`  out  7  words in frame (1..16).
- `data_in`  out  16  current word to encoder.
- `send_frame`  out  1  one-cycle frame start pulse.
- `sched_idle`  out  1  high in IDLE only.
- `err_len`, `err_tmo`  out  1 each  one-cycle error pulses.

## Operation
- States: IDLE, FETCH, START, XMIT, DRAIN, GAP.
- IDLE: when any request is present, grant it, pulse its ack and go to FETCH. Both present: master wins unless the last granted frame was master, in which case slave wins. The last-grant flag resets to "slave".
- Illegal `s_len` (5..7): pulse `s_ack` and `err_len` in the same cycle, stay in IDLE, do not change the last-grant flag. A simultaneous `m_req` is granted on the next cycle.
- Grant latches the following and holds them until return to IDLE:
  - `M_frame`/`S_frame`: exactly one high.
  - `frame_length`: 1 for master; 2^`s_len` for slave.
  - Remaining-word counter.
- FETCH:
  - Master: `data_in` ← `m_word`, go to START.
  - Slave: pulse `s_rd` with `s_addr`=0, capture `s_data` next cycle into `data_in`, then go to START.
- START: `send_frame` high for exactly one cycle, then XMIT.
- XMIT: on `enc_next`, decrement remaining.
  - If words remain (slave only), pulse `s_rd` with `s_addr`=next index on the following cycle. `data_in` updates one cycle after `s_rd`.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: wait for `enc_busy`=0, then GAP.
- GAP: count `GAP_CYCLES`, then IDLE; clear `M_frame`, `S_frame` and `frame_length` on entering IDLE.
- Timeout: progress is any `enc_next` in XMIT, or `enc_busy` falling in DRAIN. In XMIT/DRAIN, `TMO_CYCLES` consecutive cycles without progress → pulse `err_tmo`, go to GAP.
- Requests arriving outside IDLE wait; acks occur only in IDLE.

## Timing
- Reset values (async assert):
  - All outputs 0 except `sched_idle`=1.
  - State IDLE; counters 0; last-grant = slave.
  - A frame in progress is dropped without ack or error.
- Grant → `send_frame`:
  - Master: ack cycle t, `send_frame` at t+2.
  - Slave: ack at t, `s_rd` at t+1, `data_in` valid at t+2, `send_frame` at t+3.
- `data_in` is stable from `send_frame` until `enc_next`. Replacement word is valid by `enc_next`+2.
- Minimum spacing between `send_frame` pulses = frame duration + `GAP_CYCLES` + 3.
- Counters: remaining 5 bits, gap ⌈log2(GAP_CYCLES+1)⌉ bits, timeout ⌈log2(TMO_CYCLES+1)⌉ bits. None wrap; they saturate or reload.
- `enc_next` outside XMIT is ignored. An `enc_next` after the last word is ignored.

## Test plan
- Master only: `m_word`=16'h7EC3, `m_req`=1 → `m_ack` at t; `send_frame` at t+2 with `M_frame`=1, `S_frame`=0, `frame_length`=1, `data_in`=16'h7EC3; idle 48 cycles after `enc_busy` falls.
- Slave, `s_len`=2 → `frame_length`=4; `s_addr` sequence 0,1,2,3; each word appears on `data_in` in order after `enc_next`; exactly 4 `s_rd` pulses.
- `m_req` and `s_req` held continuously → grants alternate master, slave, master; first grant is master after reset.
- `s_len`=6 → `s_ack` and `err_len` in the same cycle, no `send_frame`, `sched_idle` stays 1.
- Encoder stalls with `enc_busy`=1 and no `enc_next` after START → `err_tmo` after 8192 cycles, GAP entered, then IDLE.
- `rst` low mid-XMIT of a 16-word frame → all outputs reset immediately; after release no `send_frame` until a new request.
